pe_pool: RTL
============

# pe_pool

Post-processing stage directly downstream of the convolution PE. Consumes the PE's wide accumulated `result`/`valid` stream in raster order, then applies bias, ReLU, and fixed-point rescale with saturation to 16 bits. It finally 2×2 max-pools the feature map and emits one 16-bit pooled value per 2×2 window toward the next layer's input buffer. There is no backpressure: the block accepts every `valid` beat.

## Interface
- `RES_WIDTH`, 37: width of the signed PE result.
- `OUT_WIDTH`, 16: width of the signed pooled output.
- `FRAC_SHIFT`, 8: arithmetic right shift applied after bias, for fixed-point rescale.
- `MAP_WIDTH`, 24: conv feature-map columns. Must be even, ≥2.
- `MAP_HEIGHT`, 24: conv feature-map rows. Must be even, ≥2.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `result`  in  RES_WIDTH  signed PE accumulation; sampled only when `valid`=1.
- `valid`  in  1  one conv pixel per cycle when high; gaps allowed.
- `bias`  in  OUT_WIDTH  signed bias, sign-extended to RES_WIDTH; must be held stable for a whole frame.
- `outDat`  out  OUT_WIDTH  pooled value, always ≥0.
- `outValid`  out  1  one-cycle strobe per pooled value.
- `frameDone`  out  1  one-cycle strobe coincident with the last `outValid` of a frame.

## Operation
- **Stage 1** (on `valid`): register `sum = result + sext(bias)` at RES_WIDTH+1 bits, so the add cannot overflow.
- **Stage 2**: ReLU, so `sum<0` gives 0. Then `sum >>> FRAC_SHIFT`. Then saturate to 2^(OUT_WIDTH-1)-1 (32767). The result is in the range 0..32767.
- **Raster counters**: `col` runs 0..MAP_WIDTH-1 and `row` runs 0..MAP_HEIGHT-1. Both advance once per stage-2 value.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 at the end of the frame.
- **Horizontal pair**:
  - Even `col`: store the value in `hold`.
  - Odd `col`: `hmax = max(hold, value)`.
- **Line buffer**: MAP_WIDTH/2 entries × OUT_WIDTH bits, indexed by `col>>1`.
  - Even `row`, odd `col`: write `hmax` into the buffer.
  - Odd `row`, odd `col`: emit `outDat = max(buf[col>>1], hmax)` and pulse `outValid`.
- **Frame end**: when the emitting beat has `row==MAP_HEIGHT-1` and `col==MAP_WIDTH-1`, pulse `frameDone` together with `outValid`. Counters are back at 0 for the next frame, with no idle cycle needed.
- **Output count**: each frame produces exactly (MAP_WIDTH/2)·(MAP_HEIGHT/2) outputs, in pooled raster order.
- **Reset state**: no output holds a value across reset. Line-buffer contents are not reset (every entry is written before it is read).

## Timing
- Pipeline: `result` sampled at edge N. `sum` registered at N. Activated value registered at N+1. Pooled output registered at N+2, so `outValid` is high in the cycle after edge N+2. Latency is 3 cycles from input beat to output strobe.
- Throughput is one input per cycle, sustained indefinitely. `valid` gaps of any length stall nothing. Each stage carries its own valid bit, and counters advance only on stage-2 valid.
- `outDat` holds its last value when `outValid`=0. `outValid` and `frameDone` are never high for more than 1 cycle per event.
- **Reset asserted mid-frame**, applied asynchronously:
  - pipeline valid bits clear immediately;
  - `col`, `row`, `hold` reset to 0;
  - the partial frame is discarded;
  - the first `valid` after release is pixel (0,0).
- Reset values: `outDat`=0, `outValid`=0, `frameDone`=0.
- The block does not check `bias` changes mid-frame; the result of such a change is undefined.

## Test plan
Unless stated, the bench uses MAP_WIDTH=4, MAP_HEIGHT=4, FRAC_SHIFT=2, bias=0.

1. **Basic pooling.**
   - Stimulus: rows 0/1 = {40,4,0,0}/{8,12,0,0}, rows 2/3 all 0, back-to-back.
   - Required: outputs 10,0,0,0. The first `outValid` comes 3 cycles after the 8th input beat. `frameDone` is on the 4th output.
2. **ReLU.**
   - Stimulus: all 16 results = -100.
   - Required: 4 outputs, all 0.
3. **Bias.**
   - Stimulus: all results 0, bias=20.
   - Required: 4 outputs, each 5.
   - Also: bias=-20 with results 0 gives all 0.
4. **Saturation.**
   - Stimulus: result = 2^36-1 (max positive) at every pixel, bias=32767.
   - Required: all outputs 32767, with no wrap to negative.
5. **Gapped input.**
   - Stimulus: same data as test 1, with `valid` deasserted for 0–5 random cycles between beats.
   - Required: identical output sequence. Exactly one `frameDone`, coincident with the 4th `outValid`.
6. **Reset mid-frame, then back-to-back frames.**
   - Stimulus: assert `rst_n`=0 after 6 input beats; on the same cycle `outValid`/`outDat`/`frameDone` drop to 0. Then send two full frames of test-1 data with no gap between them.
   - Required: exactly 8 outputs (10,0,0,0,10,0,0,0) and two `frameDone` pulses.

Source files
------------

// File: rtl/pe_pool_if.sv
// PE-result input beat, frame bias, and pooled output bundle for pe_pool.
// The PE side uses master; the pooling stage uses slave.
interface pe_pool_if #(
  parameter int RES_WIDTH = 37,
  parameter int OUT_WIDTH = 16
);
  logic signed [RES_WIDTH-1:0] result;
  logic                        valid;
  logic signed [OUT_WIDTH-1:0] bias;
  logic        [OUT_WIDTH-1:0] outDat;
  logic                        outValid;
  logic                        frameDone;

  modport master (
    output result, valid, bias,
    input  outDat, outValid, frameDone
  );

  modport slave (
    input  result, valid, bias,
    output outDat, outValid, frameDone
  );
endinterface

// File: rtl/pe_pool.sv
// Bias + ReLU + saturating rescale, then 2x2 max-pool of a raster conv feature map.
// Latency: 3 cycles from input beat to outValid strobe; one beat per cycle sustained.
// Backpressure: none, every valid beat is accepted and gaps simply stall nothing.
module pe_pool #(
  parameter int RES_WIDTH  = 37,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int MAP_WIDTH  = 24,
  parameter int MAP_HEIGHT = 24
) (
  input logic     clk,
  input logic     rst_n,
  pe_pool_if.slave io
);
  localparam int SW       = RES_WIDTH + 1;
  localparam int CW       = $clog2(MAP_WIDTH);
  localparam int RW       = $clog2(MAP_HEIGHT);
  localparam int LB_DEPTH = MAP_WIDTH / 2;
  localparam int LAW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_HEIGHT - 1);
  localparam logic [SW-1:0] SAT_WIDE = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_OUT = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic                 s1_vld_q, s1_vld_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [OUT_WIDTH-1:0] act_q, act_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [OUT_WIDTH-1:0] hold_q, hold_d;
  logic [OUT_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                 out_vld_q, out_vld_d;
  logic                 frame_done_q, frame_done_d;

  logic [OUT_WIDTH-1:0] lbuf_q [LB_DEPTH];
  logic [SW-1:0]        shifted;
  logic [OUT_WIDTH-1:0] hmax;
  logic [OUT_WIDTH-1:0] lb_rd;
  logic [LAW-1:0]       lb_idx;
  logic                 lb_we;

  // Stage 1 widens by one bit so result + bias can never overflow.
  always_comb begin
    s1_vld_d = io.valid;
    sum_d    = sum_q;
    if (io.valid) begin
      sum_d = {io.result[RES_WIDTH-1], io.result}
            + {{(SW-OUT_WIDTH){io.bias[OUT_WIDTH-1]}}, io.bias};
    end
  end

  always_comb begin
    s2_vld_d = s1_vld_q;
    act_d    = act_q;
    shifted  = sum_q >>> FRAC_SHIFT;
    if (s1_vld_q) begin
      if (sum_q[SW-1]) begin
        act_d = '0;
      end else if (shifted > SAT_WIDE) begin
        act_d = SAT_OUT;
      end else begin
        act_d = shifted[OUT_WIDTH-1:0];
      end
    end
  end

  assign hmax   = (act_q > hold_q) ? act_q : hold_q;
  assign lb_idx = LAW'(col_q >> 1);
  assign lb_rd  = lbuf_q[lb_idx];

  // Even rows park their horizontal max per column pair; odd rows finish the window.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_dat_d    = out_dat_q;
    out_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (s2_vld_q) begin
      if (!col_q[0]) begin
        hold_d = act_q;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_dat_d    = (lb_rd > hmax) ? lb_rd : hmax;
        out_vld_d    = 1'b1;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      sum_q        <= '0;
      s2_vld_q     <= 1'b0;
      act_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      sum_q        <= sum_d;
      s2_vld_q     <= s2_vld_d;
      act_q        <= act_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_dat_q    <= out_dat_d;
      out_vld_q    <= out_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lbuf_q[lb_idx] <= hmax;
    end
  end

  assign io.outDat    = out_dat_q;
  assign io.outValid  = out_vld_q;
  assign io.frameDone = frame_done_q;
endmodule
